// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron MAC datapath: FSM state encoding,
// width-parametrised signed clamp/range test, and lane slice offsets.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Working width for range checks; wide enough for any supported ACC_W.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t max_s(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t min_s(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // Clamp v into the signed range of a w-bit value.
  function automatic wide_t clamp_s(input wide_t v, input int w);
    if (v > max_s(w)) return max_s(w);
    if (v < min_s(w)) return min_s(w);
    return v;
  endfunction

  // True when v is representable as a w-bit signed value.
  function automatic logic fits_s(input wide_t v, input int w);
    return (v <= max_s(w)) && (v >= min_s(w));
  endfunction

  // Low bit index of lane `lane` in a packed vector of w-bit lanes.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational LANES-wide signed dot product: per-lane multiply followed by
// a full-precision sum. The caller registers the result.
module mac_lane_sum
  import neuron_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
  input  logic [LANES*DATA_W-1:0] x,
  input  logic [LANES*DATA_W-1:0] w,
  output logic signed [SUM_W-1:0] sum
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W-1:0] xi;
    logic signed [DATA_W-1:0] wi;
    assign xi = x[lane_lo(i, DATA_W) +: DATA_W];
    assign wi = w[lane_lo(i, DATA_W) +: DATA_W];
    assign prod[i] = PROD_W'(xi) * PROD_W'(wi);
  end

  // Sign-extend each product and sum; SUM_W leaves headroom for all lanes.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Multi-lane MAC for the neuron datapath: per-beat dot product, saturating
// accumulation from a bias, then optional ReLU and output-width clamp with a
// valid/ready result handshake.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16,
  parameter bit RELU   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [OUT_W-1:0]   bias_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [LANES*DATA_W-1:0]   x,
  input  logic [LANES*DATA_W-1:0]   w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat
);

  localparam int SUM_W = 2 * DATA_W + $clog2(LANES);

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    return ACC_W'(clamp_s(wide_t'(v), ACC_W));
  endfunction

  function automatic logic signed [OUT_W-1:0] clamp_out(input logic signed [ACC_W-1:0] v);
    return OUT_W'(clamp_s(wide_t'(v), OUT_W));
  endfunction

  state_t state;
  state_t state_nxt;
  logic   accept;

  logic signed [SUM_W-1:0] sum_p0;
  logic                    first_p0;

  logic signed [SUM_W-1:0] sum_p1;
  logic signed [OUT_W-1:0] bias_p1;
  logic                    first_p1;
  logic                    last_p1;
  logic                    vld_p1;

  logic signed [ACC_W-1:0] base_p1;
  logic signed [ACC_W:0]   full_p1;
  logic signed [ACC_W-1:0] acc_nxt_p1;
  logic                    ovf_p1;

  logic signed [ACC_W-1:0] acc_p2;
  logic                    sat_p2;
  logic                    last_p2;
  logic                    vld_p2;

  logic signed [ACC_W-1:0] relu_p2;
  logic signed [OUT_W-1:0] res_p2;
  logic                    clamp_p2;

  // Handshake outputs depend only on state and reset.
  assign in_ready  = !rst && ((state == IDLE) || (state == ACCUM));
  assign out_valid = !rst && (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign first_p0  = (state == IDLE);

  mac_lane_sum #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .SUM_W (SUM_W)
  ) u_lane_sum (
    .x  (x),
    .w  (w),
    .sum(sum_p0)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: DRAIN waits for the final beat to leave stage 2.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (vld_p2 && last_p2) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 0 -> 1: valid tracking for the registered lane sum.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  // Stage 0 -> 1: capture lane sum, beat tags and the vector bias.
  always_ff @(posedge clk) begin
    if (accept) begin
      sum_p1   <= sum_p0;
      first_p1 <= first_p0;
      last_p1  <= in_last;
      if (first_p0) bias_p1 <= bias_in;
    end
  end

  // Stage 1 -> 2 combinational: pick bias or running sum, add with saturation.
  always_comb begin
    base_p1    = first_p1 ? ACC_W'(bias_p1) : acc_p2;
    full_p1    = (ACC_W+1)'(base_p1) + (ACC_W+1)'(sum_p1);
    ovf_p1     = !fits_s(wide_t'(full_p1), ACC_W);
    acc_nxt_p1 = sat_acc(full_p1);
  end

  // Stage 1 -> 2: accumulator and sticky saturation flag; bubbles hold them.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2 <= '0;
      sat_p2 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        acc_p2  <= acc_nxt_p1;
        sat_p2  <= (first_p1 ? 1'b0 : sat_p2) | ovf_p1;
        last_p2 <= last_p1;
      end
    end
  end

  // Stage 2 -> out combinational: ReLU then clamp to the output width.
  always_comb begin
    relu_p2  = (RELU && acc_p2[ACC_W-1]) ? '0 : acc_p2;
    res_p2   = clamp_out(relu_p2);
    clamp_p2 = !fits_s(wide_t'(relu_p2), OUT_W);
  end

  // Stage 2 -> out: result registers load once per vector and hold in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (vld_p2 && last_p2) begin
      out_data <= res_p2;
      out_sat  <= sat_p2 | clamp_p2;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomised bench for neuron_mac: two instances (ReLU on / off) share one
// stimulus stream and are compared to an integer reference model.
module tb_neuron_mac;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 16;
  localparam longint AMAX = 64'sd8388607;
  localparam longint AMIN = -64'sd8388608;
  localparam longint OMAX = 64'sd32767;
  localparam longint OMIN = -64'sd32768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [OUT_W-1:0] bias_in;
  logic in_valid, in_last, out_ready;
  logic [LANES*DATA_W-1:0] x, w;
  logic in_ready, in_ready_n, out_valid, out_valid_n, out_sat, out_sat_n;
  logic signed [OUT_W-1:0] out_data, out_data_n;

  int checks = 0;
  int errors = 0;
  int vx [256][LANES];
  int vw [256][LANES];

  neuron_mac #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .RELU(1'b1)) dut_r (
    .clk(clk), .rst(rst), .bias_in(bias_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .x(x), .w(w), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  neuron_mac #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .RELU(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bias_in(bias_in), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_last(in_last), .x(x), .w(w), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_data(out_data_n), .out_sat(out_sat_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact dot products, accumulator saturated at ACC_W bounds each beat.
  function automatic void model_acc(input int n, input int bias, output longint acc, output bit sat);
    longint s;
    acc = bias;
    sat = 1'b0;
    for (int b = 0; b < n; b++) begin
      s = 0;
      for (int i = 0; i < LANES; i++) s += longint'(vx[b][i]) * longint'(vw[b][i]);
      acc += s;
      if (acc > AMAX) begin acc = AMAX; sat = 1'b1; end
      else if (acc < AMIN) begin acc = AMIN; sat = 1'b1; end
    end
  endfunction

  function automatic void model_out(input longint acc, input bit sat, input bit relu,
                                    output longint d, output bit s);
    longint r;
    r = (relu && acc < 0) ? 0 : acc;
    d = (r > OMAX) ? OMAX : (r < OMIN) ? OMIN : r;
    s = sat || (d != r);
  endfunction

  task automatic send_beat(input int b, input bit last, input int bias, output bit ok);
    int waited;
    waited = 0;
    for (int i = 0; i < LANES; i++) begin
      x[i*DATA_W +: DATA_W] = DATA_W'(vx[b][i]);
      w[i*DATA_W +: DATA_W] = DATA_W'(vw[b][i]);
    end
    bias_in  = OUT_W'(bias);
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    ok = in_ready;
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vector(input int n, input int bias, input int max_bub, input int hold,
                            input string tag, output longint gr, output longint gn,
                            output bit sr, output bit sn);
    bit ok;
    longint acc, er, en;
    bit sat, esr, esn;
    gr = 0; gn = 0; sr = 0; sn = 0;
    model_acc(n, bias, acc, sat);
    model_out(acc, sat, 1'b1, er, esr);
    model_out(acc, sat, 1'b0, en, esn);
    for (int b = 0; b < n; b++) begin
      if (max_bub > 0) repeat ($urandom_range(max_bub)) begin @(posedge clk); #1; end
      send_beat(b, b == n - 1, bias, ok);
      if (!ok) return;
    end
    chk({tag, "_valid_early"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid_drain"}, out_valid, 0);
    chk({tag, "_ready_drain"}, in_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_valid_norelu"}, out_valid_n, 1);
    chk({tag, "_data_relu"}, out_data, er);
    chk({tag, "_sat_relu"}, out_sat, esr);
    chk({tag, "_data_norelu"}, out_data_n, en);
    chk({tag, "_sat_norelu"}, out_sat_n, esn);
    gr = out_data; gn = out_data_n; sr = out_sat; sn = out_sat_n;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_last  = 1'($urandom_range(1));
      x = $urandom;
      w = $urandom;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_data"}, out_data, gr);
      chk({tag, "_hold_sat"}, out_sat, sr);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_release_valid"}, out_valid, 0);
    chk({tag, "_release_ready"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    longint gr, gn;
    bit sr, sn, ok;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    x = '0; w = '0; bias_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_acc", dut_r.acc_p2, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single beat vector
    vx[0] = '{1, 2, 3, 4}; vw[0] = '{1, 1, 1, 1};
    run_vector(1, 10, 0, 0, "single", gr, gn, sr, sn);
    chk("single_const", gr, 20);
    chk("single_const_sat", sr, 0);

    // Three beats with bubbles
    for (int b = 0; b < 3; b++) for (int i = 0; i < LANES; i++) begin vx[b][i] = 10; vw[b][i] = 10; end
    run_vector(3, -5, 3, 0, "three", gr, gn, sr, sn);
    chk("three_const", gr, 1195);
    chk("three_const_sat", sr, 0);

    // Negative result: ReLU vs pass-through
    for (int i = 0; i < LANES; i++) begin vx[0][i] = -1; vw[0][i] = 100; end
    run_vector(1, 0, 0, 0, "neg", gr, gn, sr, sn);
    chk("neg_relu_const", gr, 0);
    chk("neg_relu_sat", sr, 0);
    chk("neg_norelu_const", gn, -400);
    chk("neg_norelu_sat", sn, 0);

    // Output clamp, then accumulator pinned at its positive bound
    for (int b = 0; b < 131; b++) for (int i = 0; i < LANES; i++) begin vx[b][i] = 127; vw[b][i] = 127; end
    run_vector(1, 0, 0, 0, "clamp1", gr, gn, sr, sn);
    chk("clamp1_const", gr, 32767);
    chk("clamp1_sat", sr, 1);
    run_vector(131, 0, 0, 0, "pin_pos", gr, gn, sr, sn);
    chk("pin_pos_acc", dut_r.acc_p2, 8388607);
    chk("pin_pos_const", gr, 32767);
    chk("pin_pos_sat", sr, 1);

    // Negative bound: sticky sat survives ReLU zeroing
    for (int b = 0; b < 140; b++) for (int i = 0; i < LANES; i++) begin vx[b][i] = -128; vw[b][i] = 127; end
    run_vector(140, 0, 0, 0, "pin_neg", gr, gn, sr, sn);
    chk("pin_neg_acc", dut_r.acc_p2, -8388608);
    chk("pin_neg_relu", gr, 0);
    chk("pin_neg_relu_sat", sr, 1);
    chk("pin_neg_norelu", gn, -32768);
    chk("pin_neg_norelu_sat", sn, 1);

    // Backpressure for five cycles, then a fresh vector
    for (int b = 0; b < 2; b++) for (int i = 0; i < LANES; i++) begin
      vx[b][i] = int'($urandom_range(255)) - 128; vw[b][i] = int'($urandom_range(255)) - 128;
    end
    run_vector(2, 1000, 1, 5, "hold5", gr, gn, sr, sn);
    for (int i = 0; i < LANES; i++) begin vx[0][i] = i + 1; vw[0][i] = -(i + 1); end
    run_vector(1, 7, 0, 0, "after_hold", gr, gn, sr, sn);
    chk("after_hold_const", gn, -23);

    // Reset mid-vector discards the partial sum
    for (int b = 0; b < 2; b++) for (int i = 0; i < LANES; i++) begin vx[b][i] = 50; vw[b][i] = 50; end
    send_beat(0, 1'b0, 100, ok);
    send_beat(1, 1'b0, 100, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("midrst_no_output", out_valid, 0);
      @(posedge clk); #1;
    end
    vx[0] = '{1, 0, 0, 0}; vw[0] = '{5, 0, 0, 0};
    run_vector(1, 0, 0, 0, "midrst", gr, gn, sr, sn);
    chk("midrst_const", gr, 5);

    // Random vectors
    for (int v = 0; v < 25; v++) begin
      int n;
      n = int'($urandom_range(6, 1));
      for (int b = 0; b < n; b++) for (int i = 0; i < LANES; i++) begin
        vx[b][i] = int'($urandom_range(255)) - 128;
        vw[b][i] = int'($urandom_range(255)) - 128;
      end
      run_vector(n, int'($urandom_range(65535)) - 32768, 2, int'($urandom_range(3)),
                 "rand", gr, gn, sr, sn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
